// File: rtl/ram_rd_ctrl_pkg.sv
// Shared types and default sizes for the capture-RAM read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbg_ram_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 14;

    // Each RAM half holds every other sample, so its index drops the LSB.
    localparam int PAIR_W_DEF = ADDR_WIDTH_DEF - 1;

    function automatic int pair_w(input int addr_width);
        return addr_width - 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ram_rd_ctrl_if.sv
// Bus bundle between the read controller, its requesters and the two RAM halves.
// Latency: n/a (wiring only).
// Backpressure: dump stream uses dump_vld/dump_rdy; random reads use capture_rd_busy.
interface ram_rd_ctrl_if #(
    parameter int DATA_WIDTH = dbg_ram_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = dbg_ram_pkg::ADDR_WIDTH_DEF
);
    localparam int PW = ADDR_WIDTH - 1;
    localparam int HW = DATA_WIDTH / 2;

    logic                  capture_done;
    logic [ADDR_WIDTH-1:0] read_start_addr;
    logic [ADDR_WIDTH-1:0] capture_max_addr;
    logic                  capture_rd_en;
    logic [PW-1:0]         capture_rd_addr;
    logic [DATA_WIDTH-1:0] capture_rd_data;
    logic                  capture_rd_vld;
    logic                  capture_rd_busy;
    logic                  dump_start;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_vld;
    logic                  dump_rdy;
    logic                  dump_last;
    logic                  dump_done;
    logic [PW-1:0]         ram0_raddr;
    logic [PW-1:0]         ram1_raddr;
    logic                  ram0_rd_en;
    logic                  ram1_rd_en;
    logic [HW-1:0]         ram0_rdata;
    logic [HW-1:0]         ram1_rdata;

    // The controller serves requests and drives the RAM read ports.
    modport slave (
        input  capture_done, read_start_addr, capture_max_addr,
        input  capture_rd_en, capture_rd_addr, dump_start, dump_rdy,
        input  ram0_rdata, ram1_rdata,
        output capture_rd_data, capture_rd_vld, capture_rd_busy,
        output dump_data, dump_vld, dump_last, dump_done,
        output ram0_raddr, ram1_raddr, ram0_rd_en, ram1_rd_en
    );

    // Requesters plus RAM model on the far side.
    modport master (
        output capture_done, read_start_addr, capture_max_addr,
        output capture_rd_en, capture_rd_addr, dump_start, dump_rdy,
        output ram0_rdata, ram1_rdata,
        input  capture_rd_data, capture_rd_vld, capture_rd_busy,
        input  dump_data, dump_vld, dump_last, dump_done,
        input  ram0_raddr, ram1_raddr, ram0_rd_en, ram1_rd_en
    );

endinterface

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready skid buffer; head entry is presented directly on out_dat.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: holds out_vld/out_dat while out_rdy=0; writer must watch level.
module ram_rd_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [1:0]       level
);
    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = ent0_q;
    assign level   = cnt_q;
    assign pop     = out_vld && out_rdy;

    // Shift-register FIFO: entry 0 is always the oldest word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({in_vld, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        ent0_q <= in_dat;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        ent1_q <= in_dat;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= in_dat;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= in_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_rd_ctrl.sv
// Reads a circular capture buffer split over two half-width RAMs: random single reads and, with RAM_RD_CTRL_STREAM_EN, an in-order dump stream.
// Latency: RAM accessed in the request cycle, capture_rd_vld / first dump_vld two cycles later.
// Backpressure: dump_rdy stalls issue via a 2-entry skid buffer; random reads refused while capture_rd_busy.
module ram_rd_ctrl
    import dbg_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ram_rd_ctrl_if.slave bus
);
    localparam int PW = pair_w(ADDR_WIDTH);

    logic [PW-1:0] s_idx;
    logic [PW-1:0] m_idx;
    assign s_idx = bus.read_start_addr[ADDR_WIDTH-1:1];
    assign m_idx = bus.capture_max_addr[ADDR_WIDTH-1:1];

    // Offset from the oldest word to physical index, wrapping at depth M+1.
    function automatic logic [PW-1:0] phys_idx(input logic [PW-1:0] s,
                                               input logic [PW-1:0] m,
                                               input logic [PW-1:0] k);
        logic [PW:0] sum;
        sum = {1'b0, s} + {1'b0, k};
        if (sum > {1'b0, m}) begin
            sum = sum - ({1'b0, m} + (PW+1)'(1));
        end
        return sum[PW-1:0];
    endfunction

    logic          idle;
    logic          dump_go;
    logic          dmp_issue;
    logic [PW-1:0] dmp_k;

    // A dump start in the same cycle as a random request wins; the random request is dropped.
    logic rnd_req;
    logic rnd_oor;
    logic rnd_hit;
    assign rnd_req = bus.capture_rd_en && bus.capture_done && idle && !dump_go && !rst;
    assign rnd_oor = (bus.capture_rd_addr > m_idx);
    assign rnd_hit = rnd_req && !rnd_oor;

    logic          rd_en;
    logic [PW-1:0] rd_k;
    logic [PW-1:0] rd_idx;
    assign rd_en  = rnd_hit || dmp_issue;
    assign rd_k   = dmp_issue ? dmp_k : bus.capture_rd_addr;
    assign rd_idx = rd_en ? phys_idx(s_idx, m_idx, rd_k) : '0;

    assign bus.ram0_rd_en = rd_en;
    assign bus.ram1_rd_en = rd_en;
    assign bus.ram0_raddr = rd_idx;
    assign bus.ram1_raddr = rd_idx;

    logic                  rnd_q;
    logic                  rnd_oor_q;
    logic                  cap_vld_q;
    logic [DATA_WIDTH-1:0] cap_dat_q;

    // Random-read pipeline: RAM data returns one cycle after issue and is registered out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q     <= 1'b0;
            rnd_oor_q <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_dat_q <= '0;
        end else begin
            rnd_q     <= rnd_req;
            rnd_oor_q <= rnd_oor;
            cap_vld_q <= rnd_q;
            cap_dat_q <= (rnd_q && !rnd_oor_q) ? {bus.ram1_rdata, bus.ram0_rdata} : '0;
        end
    end

    assign bus.capture_rd_vld  = cap_vld_q;
    assign bus.capture_rd_data = cap_dat_q;

    logic unused_addr;
    assign unused_addr = &{1'b0, bus.read_start_addr[0], bus.capture_max_addr[0]};

`ifdef RAM_RD_CTRL_STREAM_EN
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [PW-1:0]   off_q;
    logic [PW-1:0]   off_d;
    logic            dmp_q;
    logic            dmp_last_q;
    logic            skid_vld;
    logic [DATA_WIDTH:0] skid_dat;
    logic [1:0]      level;
    logic            pop;
    logic            room;

    assign idle    = (state_q == ST_IDLE);
    assign dump_go = idle && bus.dump_start && bus.capture_done && !rst;
    assign pop     = skid_vld && bus.dump_rdy;
    // Issue only if the word in flight plus what stays after this pop leaves a free slot.
    assign room    = (({1'b0, level} + {2'b0, dmp_q} - {2'b0, pop}) < 3'd2);

    // Dump sequencer: offset 0 is issued straight from IDLE to meet the 2-cycle first-word latency.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        dmp_issue = 1'b0;
        dmp_k     = off_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_go) begin
                    dmp_issue = 1'b1;
                    dmp_k     = '0;
                    off_d     = PW'(1);
                    state_d   = (m_idx == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (room) begin
                    dmp_issue = 1'b1;
                    off_d     = off_q + PW'(1);
                    if (off_q == m_idx) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((level == 2'd0) && !dmp_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, offset counter and the in-flight tag for the word returning next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            dmp_q      <= 1'b0;
            dmp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            dmp_q      <= dmp_issue;
            dmp_last_q <= dmp_issue && (dmp_k == m_idx);
        end
    end

    ram_rd_skid #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (dmp_q),
        .in_dat  ({dmp_last_q, bus.ram1_rdata, bus.ram0_rdata}),
        .out_vld (skid_vld),
        .out_rdy (bus.dump_rdy),
        .out_dat (skid_dat),
        .level   (level)
    );

    assign bus.dump_vld        = skid_vld;
    assign bus.dump_data       = skid_dat[DATA_WIDTH-1:0];
    assign bus.dump_last       = skid_vld && skid_dat[DATA_WIDTH];
    assign bus.dump_done       = (state_q == ST_DONE);
    assign bus.capture_rd_busy = !idle || !bus.capture_done;
`else
    assign idle      = 1'b1;
    assign dump_go   = 1'b0;
    assign dmp_issue = 1'b0;
    assign dmp_k     = '0;

    assign bus.dump_vld        = 1'b0;
    assign bus.dump_data       = '0;
    assign bus.dump_last       = 1'b0;
    assign bus.dump_done       = 1'b0;
    assign bus.capture_rd_busy = !bus.capture_done;

    logic unused_stream;
    assign unused_stream = &{1'b0, bus.dump_start, bus.dump_rdy};
`endif

endmodule
